// File: rtl/light_cycle_engine.sv
// Two-player light-cycle game engine: 80x60 trail grid, frame-paced movement,
// collision arbitration and per-pixel colour generation for a raster driver.
module light_cycle_engine #(
   parameter int unsigned TICK_FRAMES = 4,
   parameter int unsigned P1_X0       = 10,
   parameter int unsigned P2_X0       = 69
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] curX,
   input  logic [11:0] curY,
   input  logic        v_sync,
   input  logic        start,
   input  logic        p1_left,
   input  logic        p1_right,
   input  logic        p2_left,
   input  logic        p2_right,
   output logic [3:0]  red_out,
   output logic [3:0]  green_out,
   output logic [3:0]  blue_out,
   output logic        game_over,
   output logic [1:0]  winner
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_PLACE, S_RUN, S_READ1, S_READ2, S_DECIDE, S_WRITE, S_OVER
   } state_t;

   localparam int unsigned CELLS = 4800;

   function automatic logic [12:0] cell_addr(input logic [6:0] col, input logic [5:0] row);
      return 13'(13'(row) * 13'd80 + 13'(col));
   endfunction

   function automatic logic is_wall(input logic [6:0] col, input logic [5:0] row);
      return (col == 7'd0) || (col == 7'd79) || (row == 6'd0) || (row == 6'd59);
   endfunction

   // Returns {col,row} one cell away in the given heading.
   function automatic logic [12:0] step(input logic [6:0] x, input logic [5:0] y,
                                        input logic [1:0] h);
      case (h)
         2'd0:    return {x, 6'(y - 6'd1)};
         2'd1:    return {7'(x + 7'd1), y};
         2'd2:    return {x, 6'(y + 6'd1)};
         default: return {7'(x - 7'd1), y};
      endcase
   endfunction

   function automatic logic [1:0] turn(input logic [1:0] h, input logic l, input logic r);
      if (l && !r) return 2'(h - 2'd1);
      if (r && !l) return 2'(h + 2'd1);
      return h;
   endfunction

   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic [12:0] clr_q, clr_d;
   logic [15:0] frame_q, frame_d;
   logic        vs_q, st_q;
   logic [3:0]  btn_q;
   logic [1:0]  pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic [6:0]  p1x_q, p1x_d, p2x_q, p2x_d, n1x_q, n1x_d, n2x_q, n2x_d;
   logic [5:0]  p1y_q, p1y_d, p2y_q, p2y_d, n1y_q, n1y_d, n2y_q, n2y_d;
   logic [1:0]  p1h_q, p1h_d, p2h_q, p2h_d;
   logic [1:0]  c1_q, c1_d, c2_q, c2_d;
   logic        go_q, go_d;
   logic [1:0]  win_q, win_d;
   logic [3:0]  red_q, green_q, blue_q;

   logic [1:0]  ram [CELLS];
   logic        eng_we;
   logic [12:0] eng_addr;
   logic [1:0]  eng_wdata, eng_rdata;

   logic        start_e, tick;
   logic [1:0]  left_e, right_e, h1, h2;
   logic [12:0] s1, s2;
   logic        crash1, crash2, same;

   logic [6:0]  r_col;
   logic [5:0]  r_row;
   logic        r_in_grid;
   logic [12:0] r_addr;
   logic [1:0]  r_data;
   logic        unused_bits;

   assign start_e = start & ~st_q;
   assign tick    = v_sync & ~vs_q;
   assign left_e  = {p2_left, p1_left} & ~{btn_q[2], btn_q[0]};
   assign right_e = {p2_right, p1_right} & ~{btn_q[3], btn_q[1]};

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      clr_d     = clr_q;
      frame_d   = frame_q;
      pend_l_d  = pend_l_q | left_e;
      pend_r_d  = pend_r_q | right_e;
      p1x_d     = p1x_q;
      p1y_d     = p1y_q;
      p1h_d     = p1h_q;
      p2x_d     = p2x_q;
      p2y_d     = p2y_q;
      p2h_d     = p2h_q;
      n1x_d     = n1x_q;
      n1y_d     = n1y_q;
      n2x_d     = n2x_q;
      n2y_d     = n2y_q;
      c1_d      = c1_q;
      c2_d      = c2_q;
      go_d      = go_q;
      win_d     = win_q;
      eng_we    = 1'b0;
      eng_addr  = '0;
      eng_wdata = '0;
      h1        = p1h_q;
      h2        = p2h_q;
      s1        = '0;
      s2        = '0;
      same      = (n1x_q == n2x_q) && (n1y_q == n2y_q);
      crash1    = is_wall(n1x_q, n1y_q) || (c1_q != 2'd0) || same;
      crash2    = is_wall(n2x_q, n2y_q) || (c2_q != 2'd0) || same;

      case (state_q)
         S_IDLE: begin
            if (start_e) begin
               clr_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            eng_we   = 1'b1;
            eng_addr = clr_q;
            if (clr_q == 13'(CELLS - 1)) begin
               phase_d = 1'b0;
               state_d = S_PLACE;
            end else begin
               clr_d = 13'(clr_q + 13'd1);
            end
         end
         // The engine port has one write per clk, so PLACE and WRITE each spend
         // two clks (phase 0 = P1 cell, phase 1 = P2 cell).
         S_PLACE: begin
            eng_we   = 1'b1;
            p1x_d    = 7'(P1_X0);
            p1y_d    = 6'd30;
            p1h_d    = 2'd1;
            p2x_d    = 7'(P2_X0);
            p2y_d    = 6'd30;
            p2h_d    = 2'd3;
            frame_d  = '0;
            pend_l_d = '0;
            pend_r_d = '0;
            if (!phase_q) begin
               eng_addr  = cell_addr(7'(P1_X0), 6'd30);
               eng_wdata = 2'd1;
               phase_d   = 1'b1;
            end else begin
               eng_addr  = cell_addr(7'(P2_X0), 6'd30);
               eng_wdata = 2'd2;
               phase_d   = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (tick) begin
               if (frame_q == 16'(TICK_FRAMES - 1)) begin
                  frame_d  = '0;
                  h1       = turn(p1h_q, pend_l_d[0], pend_r_d[0]);
                  h2       = turn(p2h_q, pend_l_d[1], pend_r_d[1]);
                  s1       = step(p1x_q, p1y_q, h1);
                  s2       = step(p2x_q, p2y_q, h2);
                  p1h_d    = h1;
                  p2h_d    = h2;
                  {n1x_d, n1y_d} = s1;
                  {n2x_d, n2y_d} = s2;
                  pend_l_d = '0;
                  pend_r_d = '0;
                  state_d  = S_READ1;
               end else begin
                  frame_d = 16'(frame_q + 16'd1);
               end
            end
         end
         S_READ1: begin
            eng_addr = cell_addr(n1x_q, n1y_q);
            c1_d     = eng_rdata;
            state_d  = S_READ2;
         end
         S_READ2: begin
            eng_addr = cell_addr(n2x_q, n2y_q);
            c2_d     = eng_rdata;
            state_d  = S_DECIDE;
         end
         S_DECIDE: begin
            if (crash1 || crash2) begin
               win_d   = {crash1, crash2};
               go_d    = 1'b1;
               state_d = S_OVER;
            end else begin
               phase_d = 1'b0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            eng_we = 1'b1;
            if (!phase_q) begin
               eng_addr  = cell_addr(n1x_q, n1y_q);
               eng_wdata = 2'd1;
               phase_d   = 1'b1;
            end else begin
               eng_addr  = cell_addr(n2x_q, n2y_q);
               eng_wdata = 2'd2;
               phase_d   = 1'b0;
               p1x_d     = n1x_q;
               p1y_d     = n1y_q;
               p2x_d     = n2x_q;
               p2y_d     = n2y_q;
               state_d   = S_RUN;
            end
         end
         S_OVER: begin
            if (start_e) begin
               go_d    = 1'b0;
               win_d   = 2'd0;
               clr_d   = '0;
               state_d = S_CLEAR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         phase_q  <= 1'b0;
         clr_q    <= '0;
         frame_q  <= '0;
         vs_q     <= 1'b0;
         st_q     <= 1'b0;
         btn_q    <= '0;
         pend_l_q <= '0;
         pend_r_q <= '0;
         p1x_q    <= '0;
         p1y_q    <= '0;
         p1h_q    <= '0;
         p2x_q    <= '0;
         p2y_q    <= '0;
         p2h_q    <= '0;
         n1x_q    <= '0;
         n1y_q    <= '0;
         n2x_q    <= '0;
         n2y_q    <= '0;
         c1_q     <= '0;
         c2_q     <= '0;
         go_q     <= 1'b0;
         win_q    <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         clr_q    <= clr_d;
         frame_q  <= frame_d;
         vs_q     <= v_sync;
         st_q     <= start;
         btn_q    <= {p2_right, p2_left, p1_right, p1_left};
         pend_l_q <= pend_l_d;
         pend_r_q <= pend_r_d;
         p1x_q    <= p1x_d;
         p1y_q    <= p1y_d;
         p1h_q    <= p1h_d;
         p2x_q    <= p2x_d;
         p2y_q    <= p2y_d;
         p2h_q    <= p2h_d;
         n1x_q    <= n1x_d;
         n1y_q    <= n1y_d;
         n2x_q    <= n2x_d;
         n2y_q    <= n2y_d;
         c1_q     <= c1_d;
         c2_q     <= c2_d;
         go_q     <= go_d;
         win_q    <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (eng_we) ram[eng_addr] <= eng_wdata;
   end

   assign eng_rdata = ram[eng_addr];

   assign r_col       = curX[9:3];
   assign r_row       = curY[8:3];
   assign r_in_grid   = (r_col < 7'd80) && (r_row < 6'd60);
   assign r_addr      = r_in_grid ? cell_addr(r_col, r_row) : '0;
   assign r_data      = ram[r_addr];
   assign unused_bits = ^{curX[11:10], curY[11:9]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {red_q, green_q, blue_q} <= '0;
      end else if (state_q == S_IDLE || state_q == S_CLEAR || !r_in_grid) begin
         {red_q, green_q, blue_q} <= '0;
      end else if (is_wall(r_col, r_row)) begin
         {red_q, green_q, blue_q} <= 12'hFFF;
      end else begin
         case (r_data)
            2'd1:    {red_q, green_q, blue_q} <= 12'h0FF;
            2'd2:    {red_q, green_q, blue_q} <= 12'hF80;
            default: {red_q, green_q, blue_q} <= '0;
         endcase
      end
   end

   assign red_out   = red_q;
   assign green_out = green_q;
   assign blue_out  = blue_q;
   assign game_over = go_q;
   assign winner    = win_q;

endmodule

// File: tb/tb_light_cycle_engine.sv
// Directed bench for light_cycle_engine: clear timing, movement, turns,
// wall and head-on crashes, mid-clear reset and a post-game grid scan.
module tb_light_cycle_engine;

   logic        clk = 1'b0;
   logic        rst_n, v_sync, start;
   logic        p1_left, p1_right, p2_left, p2_right;
   logic [11:0] curX, curY;
   logic [3:0]  red_out, green_out, blue_out;
   logic [3:0]  red2, green2, blue2;
   logic        game_over, go2;
   logic [1:0]  winner, win2;
   logic [11:0] col1, col2;
   int          n_checks = 0;
   int          n_errors = 0;

   light_cycle_engine dut (
      .clk(clk), .rst_n(rst_n), .curX(curX), .curY(curY), .v_sync(v_sync),
      .start(start), .p1_left(p1_left), .p1_right(p1_right),
      .p2_left(p2_left), .p2_right(p2_right),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .game_over(game_over), .winner(winner)
   );

   light_cycle_engine #(.TICK_FRAMES(4), .P1_X0(38), .P2_X0(40)) dut_headon (
      .clk(clk), .rst_n(rst_n), .curX(curX), .curY(curY), .v_sync(v_sync),
      .start(start), .p1_left(1'b0), .p1_right(1'b0),
      .p2_left(1'b0), .p2_right(1'b0),
      .red_out(red2), .green_out(green2), .blue_out(blue2),
      .game_over(go2), .winner(win2)
   );

   always #5 clk = ~clk;

   assign col1 = {red_out, green_out, blue_out};
   assign col2 = {red2, green2, blue2};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pix(input int x, input int y);
      curX = 12'(x);
      curY = 12'(y);
      @(negedge clk);
   endtask

   task automatic frame_tick();
      v_sync = 1'b1;
      @(negedge clk);
      v_sync = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_move();
      repeat (4) frame_tick();
      clk_n(8);
   endtask

   task automatic press_p1(input logic l, input logic r);
      p1_left  = l;
      p1_right = r;
      @(negedge clk);
      p1_left  = 1'b0;
      p1_right = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [11:0] fresh_colour(input int c, input int r);
      if (c == 0 || c == 79 || r == 0 || r == 59) return 12'hFFF;
      if (c == 10 && r == 30) return 12'h0FF;
      if (c == 69 && r == 30) return 12'hF80;
      return 12'h000;
   endfunction

   initial begin
      rst_n = 1'b0; v_sync = 1'b0; start = 1'b0;
      p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0; p2_right = 1'b0;
      curX = '0; curY = '0;
      clk_n(3);
      check("rst_colour", 32'(col1), 32'h0);
      check("rst_game_over", 32'(game_over), 32'h0);
      check("rst_winner", 32'(winner), 32'h0);
      rst_n = 1'b1;
      set_pix(0, 0);
      check("idle_blank", 32'(col1), 32'h0);

      // Start, then reset in the middle of CLEAR.
      start = 1'b1;
      clk_n(100);
      check("clear_blank", 32'(col1), 32'h0);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("midclr_rst_colour", 32'(col1), 32'h0);
      check("midclr_rst_go", 32'(game_over), 32'h0);
      clk_n(2);
      rst_n = 1'b1;
      clk_n(3);
      check("idle_after_rst", 32'(col1), 32'h0);

      // Fresh start: CLEAR spans exactly 4800 clks; ticks during it are ignored.
      start = 1'b1;
      for (int i = 1; i <= 4801; i++) begin
         @(negedge clk);
         v_sync = (i >= 1000 && i < 1006 && (i % 2) == 0);
      end
      v_sync = 1'b0;
      check("clear_len_blank", 32'(col1), 32'h0);
      @(negedge clk);
      check("clear_done_wall", 32'(col1), 32'hFFF);

      set_pix(80, 240);
      check("place_p1", 32'(col1), 32'h0FF);
      set_pix(552, 240);
      check("place_p2", 32'(col1), 32'hF80);
      set_pix(320, 240);
      check("place_empty", 32'(col1), 32'h0);
      check("headon_place_p2", 32'(col2), 32'hF80);
      set_pix(304, 240);
      check("headon_place_p1", 32'(col2), 32'h0FF);
      check("place_go", 32'(game_over), 32'h0);
      check("place_winner", 32'(winner), 32'h0);

      // Move 1: three ticks are not enough, the fourth moves both heads.
      repeat (3) frame_tick();
      clk_n(8);
      set_pix(88, 240);
      check("tick3_no_move", 32'(col1), 32'h0);
      frame_tick();
      clk_n(8);
      set_pix(88, 240);
      check("move1_p1", 32'(col1), 32'h0FF);
      set_pix(544, 240);
      check("move1_p2", 32'(col1), 32'hF80);
      set_pix(80, 240);
      check("move1_p1_trail", 32'(col1), 32'h0FF);
      set_pix(312, 240);
      check("headon_no_write", 32'(col2), 32'h0);
      check("move1_go", 32'(game_over), 32'h0);
      check("headon_go", 32'(go2), 32'h1);
      check("headon_winner", 32'(win2), 32'h3);

      // Move 2: left and right together leave the heading unchanged.
      press_p1(1'b1, 1'b1);
      do_move();
      set_pix(96, 240);
      check("both_turns_p1", 32'(col1), 32'h0FF);
      set_pix(88, 232);
      check("both_turns_not_up", 32'(col1), 32'h0);
      set_pix(0, 123);
      check("wall_col0", 32'(col1), 32'hFFF);

      // Move 3: single left turns P1 from right to up.
      press_p1(1'b1, 1'b0);
      do_move();
      set_pix(96, 232);
      check("left_turn_p1", 32'(col1), 32'h0FF);
      set_pix(104, 240);
      check("left_turn_not_right", 32'(col1), 32'h0);
      set_pix(528, 240);
      check("move3_p2", 32'(col1), 32'hF80);

      // Moves 4..31 bring P1 to row 1; move 32 hits the top wall.
      repeat (28) do_move();
      check("pre_crash_go", 32'(game_over), 32'h0);
      set_pix(96, 8);
      check("p1_row1", 32'(col1), 32'h0FF);
      do_move();
      check("crash_go", 32'(game_over), 32'h1);
      check("crash_winner", 32'(winner), 32'h2);
      set_pix(296, 240);
      check("crash_no_write_p2", 32'(col1), 32'h0);
      set_pix(304, 240);
      check("crash_p2_last", 32'(col1), 32'hF80);
      do_move();
      check("over_hold_go", 32'(game_over), 32'h1);
      check("over_hold_winner", 32'(winner), 32'h2);

      // Restart from OVER clears the flags and the whole grid.
      start = 1'b0;
      clk_n(2);
      start = 1'b1;
      @(negedge clk);
      check("restart_go", 32'(game_over), 32'h0);
      check("restart_winner", 32'(winner), 32'h0);
      clk_n(4805);
      for (int r = 0; r < 60; r++) begin
         for (int c = 0; c < 80; c++) begin
            set_pix(c * 8, r * 8);
            check("scan", 32'(col1), 32'(fresh_colour(c, r)));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
